simd_half_wb_seq: RTL and testbench
===================================

Name: simd_half_wb_seq

Overview:
Writeback sequencer for the vector lane's half-select datapath. Accepts one double-width (2*MAX_WIDTH) multiply/widening result per handshake and holds it in a single-entry buffer. Drives the internal `simd_half` selector to emit the low half, the high half, or low-then-high as MAX_WIDTH beats toward the lane writeback port. Sits between the lane multiplier output stage and the VRF write arbiter, and owns all backpressure between them.

Parameters:
- MIN_WIDTH, 8, smallest element width in bits.
- MAX_WIDTH, 64, lane datapath width in bits; output beat width.
- SEW_WIDTH, $clog2(MAX_WIDTH/MIN_WIDTH)+1, width of the one-hot sew field. bit0 = MAX_WIDTH elements; bit k = MAX_WIDTH>>k elements.

Ports:
- clk, input, 1, lane clock.
- rst, input, 1, asynchronous active-high reset.
- flush, input, 1, synchronous kill of buffered and in-flight work.
- in_valid, input, 1, input result valid.
- in_ready, output, 1, sequencer can accept the input.
- in_data, input, 2*MAX_WIDTH, widened result; each element is 2*SEW wide.
- in_sew, input, SEW_WIDTH, one-hot element width of the narrow result.
- in_mode, input, 2, 00=LOW, 01=HIGH, 10=BOTH, 11=reserved.
- out_valid, output, 1, beat valid.
- out_ready, input, 1, writeback accepts the beat.
- out_data, output, MAX_WIDTH, selected halves.
- out_high, output, 1, 1 when the current beat carries high halves.
- out_last, output, 1, final beat of the current input.
- illegal_mode, output, 1, one-cycle pulse when an in_mode=11 input is accepted.

Behaviour:
Reset (async, rst=1):
- state=IDLE, holding register invalid.
- out_valid=0, out_high=0, out_last=0, illegal_mode=0, in_ready=1 after rst deasserts.

Handshakes:
- A transfer occurs when valid&ready are both high at a rising edge.
- out_valid, once high, must not drop and out_data must not change until out_ready, unless flush or rst.

Input side:
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
- Back-to-back inputs therefore sustain 1 input per beat group with no bubble.
- in_data, in_sew and in_mode are captured into the holding register on acceptance.

Latency:
- An input accepted at edge N presents its first beat with out_valid=1 in cycle N+1. Outputs are driven from registers only.

Datapath:
- out_data = `simd_half`(high=out_high, sew=held sew, opA=held data).
- Per element: the upper or lower SEW bits of each 2*SEW chunk.

FSM states and transitions:
- IDLE: on accept, go to LO for LOW/BOTH; HI for HIGH; LO for reserved mode 11.
- LO: out_high=0, out_last = (mode!=BOTH). On out_ready:
  - mode BOTH: go to HI.
  - otherwise: go to the next accepted input's first state, else IDLE.
- HI: out_high=1, out_last=1. On out_ready: go to the next accepted input's first state, else IDLE.

Reserved mode 11:
- Treated as LOW.
- illegal_mode pulses high the cycle after acceptance.

Flush:
- flush=1 at an edge clears the holding register and forces state=IDLE. out_valid=0 in the next cycle.
- Flush has priority over a simultaneous in or out transfer; that input is dropped, not buffered.
- in_ready stays as defined during flush. An accepted input is discarded.

Other rules:
- out_ready=0 held indefinitely: state and out_data are frozen; in_ready=0 unless IDLE.
- in_sew is not checked. Non-one-hot values pass to the datapath unchanged; the result is undefined but the handshake is unaffected.
- rst asserted mid-sequence: outputs return to reset values immediately (asynchronously).

Optional Feature:
SIMD_HALF_WB_PERF_EN
- Enabled:
  - Adds outputs perf_beats (32-bit): count of out transfers.
  - Adds perf_stall (32-bit): cycles with out_valid & ~out_ready.
  - Both clear on rst, saturate at all-ones, and are not cleared by flush.
- Disabled: ports and counters are absent; all other behaviour is identical.

Test Plan:
- MAX_WIDTH=64, sew=0001, mode BOTH, in_data={64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, out_ready=1 → beat1 64'h5555..5555 (high=0, last=0), beat2 64'hAAAA..AAAA (high=1, last=1), in_ready low only during beat1.
- sew=1000, in_data=128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10:
  - mode LOW → single beat 64'h0204_0608_0A0C_0E10, last=1.
  - mode HIGH → single beat 64'h0103_0507_090B_0D0F, last=1.
- Three back-to-back LOW inputs with out_ready=1 → three beats on consecutive cycles, in_ready constantly 1, no bubble.
- mode BOTH, out_ready=0 for 5 cycles then 1 → beat1 held stable for 6 cycles, then beat2; perf_stall=5 with the macro enabled.
- flush asserted during the HI beat while in_valid=1 → next cycle out_valid=0, state IDLE, input dropped, no further beats.
- mode 11 with sew=0001 → one LOW beat equal to in_data[63:0]; illegal_mode high for exactly one cycle.

Source files
------------

// File: rtl/simd_half_wb_seq.sv
// Writeback sequencer: buffers one widened result and emits low/high halves.
// Optional perf counters: define SIMD_HALF_WB_PERF_EN.
module simd_half_wb_seq #(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int SEW_WIDTH = $clog2(MAX_WIDTH/MIN_WIDTH)+1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*MAX_WIDTH-1:0] in_data,
  input  logic [SEW_WIDTH-1:0]   in_sew,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MAX_WIDTH-1:0]   out_data,
  output logic                   out_high,
  output logic                   out_last,
  output logic                   illegal_mode
`ifdef SIMD_HALF_WB_PERF_EN
  ,
  output logic [31:0]            perf_beats,
  output logic [31:0]            perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } state_t;

  localparam logic [1:0] M_HIGH = 2'b01;
  localparam logic [1:0] M_BOTH = 2'b10;
  localparam logic [1:0] M_ILL  = 2'b11;

  state_t                 r_state;
  state_t                 w_next;
  state_t                 w_first;
  logic [2*MAX_WIDTH-1:0] r_data;
  logic [SEW_WIDTH-1:0]   r_sew;
  logic [1:0]             r_mode;
  logic                   r_illegal;
  logic                   w_acc;
  logic                   w_out_xfer;
  logic [MAX_WIDTH-1:0]   w_half;
  logic [MAX_WIDTH-1:0]   w_sel [SEW_WIDTH];

  assign out_valid    = (r_state != S_IDLE);
  assign out_high     = (r_state == S_HI);
  assign out_last     = out_high |
                        ((r_state == S_LO) && (r_mode != M_BOTH));
  assign w_out_xfer   = out_valid & out_ready;
  assign in_ready     = (r_state == S_IDLE) | (w_out_xfer & out_last);
  assign w_acc        = in_valid & in_ready;
  assign w_first      = (in_mode == M_HIGH) ? S_HI : S_LO;
  assign illegal_mode = r_illegal;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) w_next = w_first;
      end
      S_LO: begin
        if (out_ready) begin
          if (r_mode == M_BOTH) w_next = S_HI;
          else if (w_acc)       w_next = w_first;
          else                  w_next = S_IDLE;
        end
      end
      S_HI: begin
        if (out_ready) w_next = w_acc ? w_first : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // flush wins over any same-edge transfer
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_sew     <= '0;
      r_mode    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= ~flush & w_acc & (in_mode == M_ILL);
      if (flush) begin
        r_data <= '0;
        r_sew  <= '0;
        r_mode <= '0;
      end else if (w_acc) begin
        r_data <= in_data;
        r_sew  <= in_sew;
        r_mode <= in_mode;
      end
    end
  end

  // one selector per element width; sew bit k => MAX_WIDTH>>k elements
  for (genvar k = 0; k < SEW_WIDTH; k++) begin : g_sew
    localparam int EW = MAX_WIDTH >> k;
    localparam int NE = MAX_WIDTH / EW;
    for (genvar e = 0; e < NE; e++) begin : g_el
      assign w_sel[k][e*EW +: EW] = out_high ?
        r_data[e*2*EW+EW +: EW] :
        r_data[e*2*EW +: EW];
    end
  end

  always_comb begin
    w_half = '0;
    for (int k = 0; k < SEW_WIDTH; k++) begin
      if (r_sew[k]) w_half = w_half | w_sel[k];
    end
  end

  assign out_data = w_half;

`ifdef SIMD_HALF_WB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (w_out_xfer && !(&perf_beats))
        perf_beats <= perf_beats + 32'd1;
      if (out_valid && !out_ready && !(&perf_stall))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simd_half_wb_seq.sv
// Directed + scoreboard bench for simd_half_wb_seq.
// Perf checks compile only with SIMD_HALF_WB_PERF_EN.
module tb_simd_half_wb_seq;

  typedef struct {
    logic [63:0] data;
    logic        high;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_sew;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         out_high;
  logic         out_last;
  logic         illegal_mode;
`ifdef SIMD_HALF_WB_PERF_EN
  logic [31:0]  perf_beats;
  logic [31:0]  perf_stall;
`endif

  int    checks = 0;
  int    failures = 0;
  beat_t sb[$];

  simd_half_wb_seq dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sew       (in_sew),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_high     (out_high),
    .out_last     (out_last),
    .illegal_mode (illegal_mode)
`ifdef SIMD_HALF_WB_PERF_EN
    ,
    .perf_beats   (perf_beats),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // bit-level reference: bit i of element e comes from chunk e, half hi
  function automatic logic [63:0] mdl(logic [127:0] d, logic [3:0] sew,
                                      logic hi);
    logic [63:0] r;
    int w;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (sew[k]) begin
        w = 64 >> k;
        for (int i = 0; i < 64; i++)
          r[i] = r[i] | d[(i / w) * 2 * w + (hi ? w : 0) + (i % w)];
      end
    end
    return r;
  endfunction

  task automatic push_exp(logic [127:0] d, logic [3:0] s, logic [1:0] m);
    beat_t b;
    if (m == 2'b01) begin
      b.data = mdl(d, s, 1'b1); b.high = 1'b1; b.last = 1'b1;
      sb.push_back(b);
    end else if (m == 2'b10) begin
      b.data = mdl(d, s, 1'b0); b.high = 1'b0; b.last = 1'b0;
      sb.push_back(b);
      b.data = mdl(d, s, 1'b1); b.high = 1'b1; b.last = 1'b1;
      sb.push_back(b);
    end else begin
      b.data = mdl(d, s, 1'b0); b.high = 1'b0; b.last = 1'b1;
      sb.push_back(b);
    end
  endtask

  // sample at negedge, advance to just after the next posedge
  task automatic cyc();
    beat_t b;
    @(negedge clk);
    if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_beat", {63'd0, out_valid}, 64'd0);
        end else begin
          b = sb.pop_front();
          chk("sb_data", out_data, b.data);
          chk("sb_high", {63'd0, out_high}, {63'd0, b.high});
          chk("sb_last", {63'd0, out_last}, {63'd0, b.last});
        end
      end
      if (in_valid && in_ready) push_exp(in_data, in_sew, in_mode);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [127:0] d, logic [3:0] s,
                       logic [1:0] m);
    in_valid = v;
    in_data  = d;
    in_sew   = s;
    in_mode  = m;
  endtask

  localparam logic [127:0] D_AA55 =
    {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
  localparam logic [127:0] D_SEQ =
    128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, 4'b0001, 2'b00);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_high", {63'd0, out_high}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_illegal", {63'd0, illegal_mode}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // BOTH, sew=64
    drive(1'b1, D_AA55, 4'b0001, 2'b10);
    cyc();
    drive(1'b0, '0, 4'b0001, 2'b00);
    chk("both_b1_valid", {63'd0, out_valid}, 64'd1);
    chk("both_b1_data", out_data, 64'h5555_5555_5555_5555);
    chk("both_b1_hl", {62'd0, out_high, out_last}, 64'd0);
    chk("both_b1_in_ready", {63'd0, in_ready}, 64'd0);
    cyc();
    chk("both_b2_data", out_data, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("both_b2_hl", {62'd0, out_high, out_last}, 64'd3);
    chk("both_b2_in_ready", {63'd0, in_ready}, 64'd1);
    cyc();
    chk("both_done", {63'd0, out_valid}, 64'd0);

    // sew=8 LOW then HIGH
    drive(1'b1, D_SEQ, 4'b1000, 2'b00);
    cyc();
    drive(1'b0, '0, 4'b0001, 2'b00);
    chk("sew8_low", out_data, 64'h0204_0608_0A0C_0E10);
    chk("sew8_low_last", {63'd0, out_last}, 64'd1);
    cyc();
    drive(1'b1, D_SEQ, 4'b1000, 2'b01);
    cyc();
    drive(1'b0, '0, 4'b0001, 2'b00);
    chk("sew8_high", out_data, 64'h0103_0507_090B_0D0F);
    chk("sew8_high_hl", {62'd0, out_high, out_last}, 64'd3);
    cyc();

    // three back-to-back LOW inputs
    drive(1'b1, {64'h0, 64'h1111}, 4'b0001, 2'b00);
    chk("b2b_in_ready0", {63'd0, in_ready}, 64'd1);
    cyc();
    drive(1'b1, {64'h0, 64'h2222}, 4'b0001, 2'b00);
    chk("b2b_in_ready1", {63'd0, in_ready}, 64'd1);
    chk("b2b_valid1", {63'd0, out_valid}, 64'd1);
    cyc();
    drive(1'b1, {64'h0, 64'h3333}, 4'b0001, 2'b00);
    chk("b2b_in_ready2", {63'd0, in_ready}, 64'd1);
    chk("b2b_valid2", {63'd0, out_valid}, 64'd1);
    cyc();
    drive(1'b0, '0, 4'b0001, 2'b00);
    chk("b2b_valid3", {63'd0, out_valid}, 64'd1);
    chk("b2b_data3", out_data, 64'h3333);
    cyc();
    chk("b2b_done", {63'd0, out_valid}, 64'd0);

    // BOTH with 5 stall cycles
    out_ready = 1'b0;
    drive(1'b1, D_AA55, 4'b0001, 2'b10);
    cyc();
    drive(1'b0, '0, 4'b0001, 2'b00);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_data", out_data, 64'h5555_5555_5555_5555);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      cyc();
    end
    out_ready = 1'b1;
    chk("stall_b1_data", out_data, 64'h5555_5555_5555_5555);
    cyc();
    chk("stall_b2_high", {63'd0, out_high}, 64'd1);
    cyc();
`ifdef SIMD_HALF_WB_PERF_EN
    chk("perf_stall", {32'd0, perf_stall}, 64'd5);
    chk("perf_beats", {32'd0, perf_beats}, 64'd9);
`endif

    // flush during HI while an input is offered
    drive(1'b1, D_AA55, 4'b0001, 2'b10);
    cyc();
    drive(1'b0, '0, 4'b0001, 2'b00);
    cyc();
    chk("flush_in_hi", {63'd0, out_high}, 64'd1);
    drive(1'b1, D_SEQ, 4'b1000, 2'b10);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, 4'b0001, 2'b00);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_no_beats", {63'd0, out_valid}, 64'd0);
    end

    // reserved mode
    drive(1'b1, D_SEQ, 4'b0001, 2'b11);
    cyc();
    drive(1'b0, '0, 4'b0001, 2'b00);
    chk("ill_data", out_data, 64'h090A_0B0C_0D0E_0F10);
    chk("ill_hl", {62'd0, out_high, out_last}, 64'd1);
    chk("ill_pulse", {63'd0, illegal_mode}, 64'd1);
    cyc();
    chk("ill_pulse_end", {63'd0, illegal_mode}, 64'd0);
    chk("ill_done", {63'd0, out_valid}, 64'd0);

    // random traffic against the scoreboard
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(1)),
            {$urandom, $urandom, $urandom, $urandom},
            4'b0001 << $urandom_range(3),
            2'($urandom_range(3)));
      out_ready = 1'($urandom_range(1));
      cyc();
    end
    drive(1'b0, '0, 4'b0001, 2'b00);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) cyc();
    chk("rand_drained", 64'(sb.size()), 64'd0);
    cyc();
    chk("rand_idle", {63'd0, out_valid}, 64'd0);

    // async reset mid-sequence
    drive(1'b1, D_AA55, 4'b0001, 2'b10);
    cyc();
    drive(1'b0, '0, 4'b0001, 2'b00);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_hl", {62'd0, out_high, out_last}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    #1 chk("arst_in_ready", {63'd0, in_ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
